// File: rtl/cop0_pkg.sv
// Shared constants for the coprocessor-0 block: op encodings, register map, field positions.
package cop0_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_NUM_W = 5;
    localparam int unsigned SEL_W     = 3;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned CODE_W    = 20;
    localparam int unsigned EXCCODE_W = 5;

    typedef enum logic [OP_W-1:0] {
        COP_NONE    = 3'd0,
        COP_SYSCALL = 3'd1,
        COP_BREAK   = 3'd2,
        COP_ERET    = 3'd3,
        COP_RI      = 3'd4
    } cop_op_e;

    localparam logic [REG_NUM_W-1:0] CP0_COUNT   = 5'd9;
    localparam logic [REG_NUM_W-1:0] CP0_COMPARE = 5'd11;
    localparam logic [REG_NUM_W-1:0] CP0_STATUS  = 5'd12;
    localparam logic [REG_NUM_W-1:0] CP0_CAUSE   = 5'd13;
    localparam logic [REG_NUM_W-1:0] CP0_EPC     = 5'd14;
    localparam logic [REG_NUM_W-1:0] CP0_PRID    = 5'd15;
    localparam logic [REG_NUM_W-1:0] CP0_EXCINFO = 5'd22;

    localparam logic [EXCCODE_W-1:0] EXC_SYS = 5'd8;
    localparam logic [EXCCODE_W-1:0] EXC_BP  = 5'd9;
    localparam logic [EXCCODE_W-1:0] EXC_RI  = 5'd10;

    localparam logic [DATA_W-1:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [DATA_W-1:0] CAUSE_WMASK  = 32'h0000_0300;

    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned FIELD_IM_LO  = 8;
    localparam int unsigned FIELD_IM_HI  = 15;
    localparam int unsigned CAUSE_IP7    = 15;
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_EXC_HI = 6;

    // True for the ops that take an exception (SYSCALL, BREAK, RI)
    function automatic logic is_exception(input logic [OP_W-1:0] op);
        return (op == COP_SYSCALL) || (op == COP_BREAK) || (op == COP_RI);
    endfunction

    // ExcCode recorded for each exception-taking op
    function automatic logic [EXCCODE_W-1:0] exc_code_of(input logic [OP_W-1:0] op);
        logic [EXCCODE_W-1:0] code;
        case (op)
            COP_SYSCALL: code = EXC_SYS;
            COP_BREAK:   code = EXC_BP;
            default:     code = EXC_RI;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cop0_if.sv
// Datapath <-> COP0 access bus: MTC0/MFC0, exception ops, PC redirect and interrupt.
interface cop0_if;
    import cop0_pkg::*;

    logic [REG_NUM_W-1:0] reg_num;
    logic [SEL_W-1:0]     reg_sel;
    logic [DATA_W-1:0]    in_data;
    logic [DATA_W-1:0]    next_pc;
    logic                 reg_wr;
    logic                 reg_rd;
    logic [OP_W-1:0]      cop_op;
    logic [CODE_W-1:0]    code;
    logic [DATA_W-1:0]    out_data;
    logic                 exc_redirect;
    logic [DATA_W-1:0]    redirect_pc;
    logic                 irq;

    modport master (
        output reg_num, reg_sel, in_data, next_pc, reg_wr, reg_rd, cop_op, code,
        input  out_data, exc_redirect, redirect_pc, irq
    );

    modport slave (
        input  reg_num, reg_sel, in_data, next_pc, reg_wr, reg_rd, cop_op, code,
        output out_data, exc_redirect, redirect_pc, irq
    );

endinterface

// File: rtl/cop0.sv
// MIPS coprocessor 0: control register file, exception/ERET bookkeeping and timer interrupt.
module cop0
    import cop0_pkg::*;
#(
    parameter logic [DATA_W-1:0] PRID       = 32'h0001_8000,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic   clk,
    input  logic   rst,
    cop0_if.slave  io_bus
);

    logic [DATA_W-1:0] r_count;
    logic [DATA_W-1:0] r_compare;
    logic [DATA_W-1:0] r_status;
    logic [DATA_W-1:0] r_cause;
    logic [DATA_W-1:0] r_epc;
    logic [CODE_W-1:0] r_excinfo;

    logic [DATA_W-1:0] w_count_nxt;
    logic [DATA_W-1:0] w_compare_nxt;
    logic [DATA_W-1:0] w_status_nxt;
    logic [DATA_W-1:0] w_cause_nxt;
    logic [DATA_W-1:0] w_epc_nxt;
    logic [CODE_W-1:0] w_excinfo_nxt;

    logic              w_sel0;
    logic              w_wr_count;
    logic              w_wr_compare;
    logic              w_wr_status;
    logic              w_wr_cause;
    logic              w_wr_epc;
    logic              w_exc;
    logic              w_eret;
    logic              w_save_code;
    logic              w_match;
    logic [DATA_W-1:0] w_rd_data;

    // Address decode of MTC0 targets and classification of the current op
    always_comb begin
        w_sel0       = (io_bus.reg_sel == '0);
        w_wr_count   = io_bus.reg_wr && w_sel0 && (io_bus.reg_num == CP0_COUNT);
        w_wr_compare = io_bus.reg_wr && w_sel0 && (io_bus.reg_num == CP0_COMPARE);
        w_wr_status  = io_bus.reg_wr && w_sel0 && (io_bus.reg_num == CP0_STATUS);
        w_wr_cause   = io_bus.reg_wr && w_sel0 && (io_bus.reg_num == CP0_CAUSE);
        w_wr_epc     = io_bus.reg_wr && w_sel0 && (io_bus.reg_num == CP0_EPC);
        w_exc        = is_exception(io_bus.cop_op);
        w_eret       = (io_bus.cop_op == COP_ERET);
        w_save_code  = (io_bus.cop_op == COP_SYSCALL) || (io_bus.cop_op == COP_BREAK);
        w_match      = (r_count == r_compare);
    end

    // Next register values: MTC0 first, then exception/ERET effects layered on top
    always_comb begin
        w_count_nxt   = w_wr_count ? io_bus.in_data : r_count + DATA_W'(1);
        w_compare_nxt = w_wr_compare ? io_bus.in_data : r_compare;

        w_status_nxt = w_wr_status ? (io_bus.in_data & STATUS_WMASK) : r_status;
        if (w_exc) begin
            w_status_nxt[STATUS_EXL] = 1'b1;
        end else if (w_eret) begin
            w_status_nxt[STATUS_EXL] = 1'b0;
        end

        w_cause_nxt = r_cause;
        if (w_wr_cause) begin
            w_cause_nxt = (r_cause & ~CAUSE_WMASK) | (io_bus.in_data & CAUSE_WMASK);
        end
        // Timer IP is sticky; a Compare write acknowledges it even on a match cycle
        if (w_wr_compare) begin
            w_cause_nxt[CAUSE_IP7] = 1'b0;
        end else if (w_match) begin
            w_cause_nxt[CAUSE_IP7] = 1'b1;
        end
        if (w_exc) begin
            w_cause_nxt[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_of(io_bus.cop_op);
        end

        w_epc_nxt = w_wr_epc ? io_bus.in_data : r_epc;
        if (w_exc) begin
            w_epc_nxt = io_bus.next_pc;
        end

        w_excinfo_nxt = w_save_code ? io_bus.code : r_excinfo;
    end

    // Register file update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_compare <= '0;
            r_status  <= '0;
            r_cause   <= '0;
            r_epc     <= '0;
            r_excinfo <= '0;
        end else begin
            r_count   <= w_count_nxt;
            r_compare <= w_compare_nxt;
            r_status  <= w_status_nxt;
            r_cause   <= w_cause_nxt;
            r_epc     <= w_epc_nxt;
            r_excinfo <= w_excinfo_nxt;
        end
    end

    // MFC0 read mux; unmapped (reg,sel) pairs read zero
    always_comb begin
        w_rd_data = '0;
        if (w_sel0) begin
            case (io_bus.reg_num)
                CP0_COUNT:   w_rd_data = r_count;
                CP0_COMPARE: w_rd_data = r_compare;
                CP0_STATUS:  w_rd_data = r_status;
                CP0_CAUSE:   w_rd_data = r_cause;
                CP0_EPC:     w_rd_data = r_epc;
                CP0_PRID:    w_rd_data = PRID;
                CP0_EXCINFO: w_rd_data = DATA_W'(r_excinfo);
                default:     w_rd_data = '0;
            endcase
        end
        io_bus.out_data = io_bus.reg_rd ? w_rd_data : '0;
    end

    // PC redirect for exception entry and ERET
    always_comb begin
        io_bus.exc_redirect = 1'b0;
        io_bus.redirect_pc  = '0;
        if (w_exc) begin
            io_bus.exc_redirect = 1'b1;
            io_bus.redirect_pc  = EXC_VECTOR;
        end else if (w_eret) begin
            io_bus.exc_redirect = 1'b1;
            io_bus.redirect_pc  = r_epc;
        end
    end

    // Maskable interrupt request, suppressed while in exception level
    assign io_bus.irq = r_status[STATUS_IE] & ~r_status[STATUS_EXL]
                      & (|(r_cause[FIELD_IM_HI:FIELD_IM_LO] & r_status[FIELD_IM_HI:FIELD_IM_LO]));

endmodule

// File: tb/tb_cop0.sv
// Self-checking bench for cop0: directed table, timer/reset sequences, randomized run vs model.
module tb_cop0;
    import cop0_pkg::*;

    localparam logic [31:0] PRID_V = 32'h0001_8000;
    localparam logic [31:0] EXC_V  = 32'h8000_0180;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cop0_if bus();

    cop0 #(.PRID(PRID_V), .EXC_VECTOR(EXC_V)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Field-level architectural model
    logic [31:0] m_count, m_compare, m_epc;
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_ip7;
    logic [1:0]  m_ip10;
    logic [4:0]  m_exc;
    logic [19:0] m_info;

    typedef struct {
        logic [4:0]  rn;
        logic [2:0]  rs;
        logic        wr;
        logic        rd;
        logic [31:0] din;
        logic [2:0]  op;
        logic [31:0] npc;
        logic [19:0] cd;
        logic [31:0] e_out;
        logic        e_redir;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [4:0] rn, input logic [2:0] rs, input logic wr,
                                input logic rd, input logic [31:0] din, input logic [2:0] op,
                                input logic [31:0] npc, input logic [19:0] cd,
                                input logic [31:0] e_out, input logic e_redir,
                                input logic [31:0] e_rpc);
        vec_t v;
        v.rn = rn; v.rs = rs; v.wr = wr; v.rd = rd; v.din = din; v.op = op;
        v.npc = npc; v.cd = cd; v.e_out = e_out; v.e_redir = e_redir; v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] rn, input logic [2:0] rs);
        if (rs != 3'd0) return 32'h0;
        case (rn)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return {16'h0, m_im, 6'h0, m_exl, m_ie};
            5'd13:   return {16'h0, m_ip7, 5'h0, m_ip10, 1'b0, m_exc, 2'b00};
            5'd14:   return m_epc;
            5'd15:   return PRID_V;
            5'd22:   return {12'h0, m_info};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_irq();
        logic [7:0] ip;
        ip = {m_ip7, 5'h0, m_ip10};
        return m_ie & ~m_exl & (|(ip & m_im));
    endfunction

    // Advance the model by one clock using the inputs currently on the bus
    task automatic m_step();
        logic       w;
        logic [4:0] rn;
        logic [2:0] op;
        if (rst) begin
            m_count = 0; m_compare = 0; m_epc = 0; m_im = 0; m_exl = 0; m_ie = 0;
            m_ip7 = 0; m_ip10 = 0; m_exc = 0; m_info = 0;
            return;
        end
        w  = bus.reg_wr && (bus.reg_sel == 3'd0);
        rn = bus.reg_num;
        op = bus.cop_op;
        if (w && rn == 5'd11)            m_ip7 = 1'b0;
        else if (m_count == m_compare)   m_ip7 = 1'b1;
        m_count = (w && rn == 5'd9) ? bus.in_data : m_count + 32'd1;
        if (w && rn == 5'd11) m_compare = bus.in_data;
        if (w && rn == 5'd12) begin
            m_im = bus.in_data[15:8]; m_exl = bus.in_data[1]; m_ie = bus.in_data[0];
        end
        if (w && rn == 5'd13) m_ip10 = bus.in_data[9:8];
        if (w && rn == 5'd14) m_epc = bus.in_data;
        if (op == 3'd1 || op == 3'd2 || op == 3'd4) begin
            m_exl = 1'b1;
            m_epc = bus.next_pc;
            m_exc = (op == 3'd1) ? 5'd8 : (op == 3'd2) ? 5'd9 : 5'd10;
        end
        if (op == 3'd1 || op == 3'd2) m_info = bus.code;
        if (op == 3'd3) m_exl = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] e_out, e_rpc;
        logic        e_red;
        e_out = bus.reg_rd ? m_read(bus.reg_num, bus.reg_sel) : 32'h0;
        case (bus.cop_op)
            3'd1, 3'd2, 3'd4: begin e_red = 1'b1; e_rpc = EXC_V; end
            3'd3:             begin e_red = 1'b1; e_rpc = m_epc; end
            default:          begin e_red = 1'b0; e_rpc = 32'h0; end
        endcase
        chk({tag, "_out"}, bus.out_data, e_out);
        chk({tag, "_redir"}, 32'(bus.exc_redirect), 32'(e_red));
        chk({tag, "_rpc"}, bus.redirect_pc, e_rpc);
        chk({tag, "_irq"}, 32'(bus.irq), 32'(m_irq()));
    endtask

    task automatic drive(input logic [4:0] rn, input logic [2:0] rs, input logic wr,
                         input logic rd, input logic [31:0] din, input logic [2:0] op,
                         input logic [31:0] npc, input logic [19:0] cd);
        bus.reg_num = rn; bus.reg_sel = rs; bus.reg_wr = wr; bus.reg_rd = rd;
        bus.in_data = din; bus.cop_op = op; bus.next_pc = npc; bus.code = cd;
    endtask

    task automatic rd_reg(input logic [4:0] rn);
        drive(rn, 3'd0, 1'b0, 1'b1, 32'h0, 3'd0, 32'h0, 20'h0);
    endtask

    task automatic wr_reg(input logic [4:0] rn, input logic [31:0] din);
        drive(rn, 3'd0, 1'b1, 1'b0, din, 3'd0, 32'h0, 20'h0);
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rnd_regs[8];
        rnd_regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd22, 5'd3};

        drive(5'd0, 3'd0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 20'h0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state, all sampled inside the first post-reset cycle
        rd_reg(5'd12); #1 chk("rst_status", bus.out_data, 32'h0);
        rd_reg(5'd13); #1 chk("rst_cause", bus.out_data, 32'h0);
        rd_reg(5'd14); #1 chk("rst_epc", bus.out_data, 32'h0);
        rd_reg(5'd9);  #1 chk("rst_count", bus.out_data, 32'h0);
        rd_reg(5'd15); #1 chk("rst_prid", bus.out_data, PRID_V);
        drive(5'd15, 3'd0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 20'h0);
        #1 chk("rst_rd0", bus.out_data, 32'h0);
        chk("rst_irq", 32'(bus.irq), 32'h0);
        chk("rst_redir", 32'(bus.exc_redirect), 32'h0);
        tick();

        // Directed table: expected values are pre-edge combinational outputs
        tv.push_back(mk(5'd11, 3'd0, 1, 1, 32'hFFFF_0000, 3'd0, 32'h0, 20'h0, 32'h0, 0, 32'h0));
        tv.push_back(mk(5'd14, 3'd0, 1, 1, 32'hDEAD_BEEF, 3'd0, 32'h0, 20'h0, 32'h0, 0, 32'h0));
        tv.push_back(mk(5'd14, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'hDEAD_BEEF, 0, 32'h0));
        tv.push_back(mk(5'd12, 3'd0, 1, 1, 32'hFFFF_FFFF, 3'd0, 32'h0, 20'h0, 32'h0, 0, 32'h0));
        tv.push_back(mk(5'd12, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0000_FF03, 0, 32'h0));
        tv.push_back(mk(5'd12, 3'd0, 1, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0000_FF03, 0, 32'h0));
        tv.push_back(mk(5'd14, 3'd1, 1, 1, 32'h1234_5678, 3'd0, 32'h0, 20'h0, 32'h0, 0, 32'h0));
        tv.push_back(mk(5'd14, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'hDEAD_BEEF, 0, 32'h0));
        tv.push_back(mk(5'd14, 3'd0, 0, 1, 32'h0, 3'd1, 32'h0040_0010, 20'hABCDE, 32'hDEAD_BEEF, 1, EXC_V));
        tv.push_back(mk(5'd14, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0040_0010, 0, 32'h0));
        tv.push_back(mk(5'd13, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0000_0020, 0, 32'h0));
        tv.push_back(mk(5'd12, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0000_0002, 0, 32'h0));
        tv.push_back(mk(5'd22, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h000A_BCDE, 0, 32'h0));
        tv.push_back(mk(5'd12, 3'd0, 0, 1, 32'h0, 3'd3, 32'h0, 20'h0, 32'h0000_0002, 1, 32'h0040_0010));
        tv.push_back(mk(5'd12, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0, 0, 32'h0));
        tv.push_back(mk(5'd13, 3'd0, 0, 1, 32'h0, 3'd2, 32'h0040_0020, 20'h12345, 32'h0000_0020, 1, EXC_V));
        tv.push_back(mk(5'd13, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0000_0024, 0, 32'h0));
        tv.push_back(mk(5'd22, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0001_2345, 0, 32'h0));
        tv.push_back(mk(5'd22, 3'd0, 0, 1, 32'h0, 3'd4, 32'h0040_0030, 20'hFFFFF, 32'h0001_2345, 1, EXC_V));
        tv.push_back(mk(5'd13, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0000_0028, 0, 32'h0));
        tv.push_back(mk(5'd22, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0001_2345, 0, 32'h0));
        tv.push_back(mk(5'd12, 3'd0, 0, 1, 32'h0, 3'd3, 32'h0, 20'h0, 32'h0000_0002, 1, 32'h0040_0030));
        tv.push_back(mk(5'd12, 3'd0, 0, 0, 32'h0, 3'd5, 32'h0, 20'h0, 32'h0, 0, 32'h0));
        tv.push_back(mk(5'd13, 3'd0, 1, 1, 32'hFFFF_FFFF, 3'd0, 32'h0, 20'h0, 32'h0000_0028, 0, 32'h0));
        tv.push_back(mk(5'd13, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0000_0328, 0, 32'h0));
        tv.push_back(mk(5'd13, 3'd0, 1, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0000_0328, 0, 32'h0));
        tv.push_back(mk(5'd13, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0000_0028, 0, 32'h0));
        tv.push_back(mk(5'd14, 3'd0, 1, 1, 32'h0000_1234, 3'd1, 32'h0040_0040, 20'h00777, 32'h0040_0030, 1, EXC_V));
        tv.push_back(mk(5'd14, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0040_0040, 0, 32'h0));
        tv.push_back(mk(5'd22, 3'd0, 0, 1, 32'h0, 3'd3, 32'h0, 20'h0, 32'h0000_0777, 1, 32'h0040_0040));
        tv.push_back(mk(5'd12, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0, 0, 32'h0));
        tv.push_back(mk(5'd5,  3'd0, 1, 1, 32'hFFFF_FFFF, 3'd0, 32'h0, 20'h0, 32'h0, 0, 32'h0));
        tv.push_back(mk(5'd5,  3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0, 0, 32'h0));
        tv.push_back(mk(5'd15, 3'd0, 1, 1, 32'h0, 3'd0, 32'h0, 20'h0, PRID_V, 0, 32'h0));
        tv.push_back(mk(5'd15, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, PRID_V, 0, 32'h0));
        tv.push_back(mk(5'd22, 3'd0, 1, 1, 32'hFFFF_FFFF, 3'd0, 32'h0, 20'h0, 32'h0000_0777, 0, 32'h0));
        tv.push_back(mk(5'd22, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0000_0777, 0, 32'h0));
        tv.push_back(mk(5'd13, 3'd0, 0, 1, 32'h0, 3'd0, 32'h0, 20'h0, 32'h0000_0020, 0, 32'h0));

        foreach (tv[i]) begin
            drive(tv[i].rn, tv[i].rs, tv[i].wr, tv[i].rd, tv[i].din, tv[i].op, tv[i].npc, tv[i].cd);
            #1;
            chk($sformatf("tv%0d_out", i), bus.out_data, tv[i].e_out);
            chk($sformatf("tv%0d_redir", i), 32'(bus.exc_redirect), 32'(tv[i].e_redir));
            chk($sformatf("tv%0d_rpc", i), bus.redirect_pc, tv[i].e_rpc);
            check_model($sformatf("tv%0d_m", i));
            tick();
        end

        // Timer interrupt: Compare=5, Count=0, IE with IM[7]
        wr_reg(5'd12, 32'h0000_8001); tick();
        wr_reg(5'd11, 32'd5);         tick();
        wr_reg(5'd9,  32'd0);         tick();
        for (int i = 0; i < 6; i++) begin
            rd_reg(5'd9);
            #1;
            chk($sformatf("tmr_count%0d", i), bus.out_data, 32'(i));
            chk($sformatf("tmr_noirq%0d", i), 32'(bus.irq), 32'h0);
            tick();
        end
        rd_reg(5'd13);
        #1;
        chk("tmr_ip7_set", 32'(bus.out_data[15]), 32'h1);
        chk("tmr_irq", 32'(bus.irq), 32'h1);
        check_model("tmr_m");
        tick();
        wr_reg(5'd12, 32'h0000_8003);
        #1 chk("tmr_irq_hold", 32'(bus.irq), 32'h1);
        tick();
        rd_reg(5'd12);
        #1 chk("tmr_exl_mask", 32'(bus.irq), 32'h0);
        tick();
        wr_reg(5'd11, 32'hFFFF_0000); tick();
        rd_reg(5'd13);
        #1 chk("tmr_ip7_clr", 32'(bus.out_data[15]), 32'h0);
        tick();
        drive(5'd0, 3'd0, 1'b0, 1'b0, 32'h0, 3'd3, 32'h0, 20'h0); tick();

        // Compare write on the very cycle Count==Compare: clear wins
        wr_reg(5'd11, 32'd100); tick();
        wr_reg(5'd9,  32'd100); tick();
        drive(5'd11, 3'd0, 1'b1, 1'b0, 32'd200, 3'd0, 32'h0, 20'h0);
        #1 check_model("race_m");
        tick();
        rd_reg(5'd13);
        #1;
        chk("race_ip7", 32'(bus.out_data[15]), 32'h0);
        chk("race_irq", 32'(bus.irq), 32'h0);
        tick();

        // Reset mid-sequence overrides a concurrent write and exception
        rd_reg(5'd22);
        #1 chk("pre_rst_info", bus.out_data, 32'h0000_0777);
        drive(5'd14, 3'd0, 1'b1, 1'b1, 32'h5555_5555, 3'd1, 32'h1111_1110, 20'hBEEF0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_reg(5'd9);  #1 chk("mrst_count", bus.out_data, 32'h0);
        rd_reg(5'd11); #1 chk("mrst_compare", bus.out_data, 32'h0);
        rd_reg(5'd12); #1 chk("mrst_status", bus.out_data, 32'h0);
        rd_reg(5'd13); #1 chk("mrst_cause", bus.out_data, 32'h0);
        rd_reg(5'd14); #1 chk("mrst_epc", bus.out_data, 32'h0);
        rd_reg(5'd22); #1 chk("mrst_info", bus.out_data, 32'h0);
        rd_reg(5'd15); #1 chk("mrst_prid", bus.out_data, PRID_V);
        chk("mrst_irq", 32'(bus.irq), 32'h0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [4:0]  rn;
            logic [2:0]  rs, op;
            logic [31:0] din;
            rn  = rnd_regs[$urandom_range(0, 7)];
            rs  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            din = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            op  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            drive(rn, rs, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), din, op,
                  32'($urandom), 20'($urandom));
            rst = ($urandom_range(0, 199) == 0);
            #1 check_model($sformatf("rnd%0d", n));
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
